shiftadd_arbiter: RTL and testbench

//  Shares one shiftadd sequential multiplier between two requesters.

---
 rtl/shiftadd_arbiter.sv | 79 +++++++
 tb/tb_shiftadd_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shiftadd_arbiter.sv
// shiftadd_arbiter: round-robin sharing of one sequential multiplier between two requesters with a watchdog
module shiftadd_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               ack0,
  output logic [2*WIDTH-1:0] res0,
  output logic               err0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack1,
  output logic [2*WIDTH-1:0] res1,
  output logic               err1,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_flag,
  input  logic [2*WIDTH-1:0] mul_res
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t state, nxt;
  logic gnt, last, pick, hit, expire, finish;
  logic [CW-1:0] cnt;
  assign pick   = (req0 & req1) ? ~last : req1;
  assign hit    = (cnt != '0) & mul_flag;
  assign expire = cnt == CW'(TIMEOUT - 1);
  assign finish = (state == WAIT) & (hit | expire);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next-state: a stale flag at cnt==0 is never a completion
  always_comb
    nxt = state == IDLE   ? ((req0 | req1) ? LAUNCH : IDLE) :
          state == LAUNCH ? WAIT :
          state == WAIT   ? ((hit | expire) ? DONE : WAIT) : IDLE;
  // outputs decoded from state: start and acks are single-cycle by construction
  always_comb begin
    mul_start = state == LAUNCH;
    ack0      = (state == DONE) & ~gnt;
    ack1      = (state == DONE) & gnt;
  end
  // grant/operand capture, wait counter, result latching and round-robin pointer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      res0  <= '0;
      res1  <= '0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == IDLE && (req0 | req1)) begin
        gnt   <= pick;
        mul_a <= pick ? a1 : a0;
        mul_b <= pick ? b1 : b0;
      end
      if (finish && !gnt) begin
        res0 <= hit ? mul_res : '0;
        err0 <= ~hit;
      end
      if (finish && gnt) begin
        res1 <= hit ? mul_res : '0;
        err1 <= ~hit;
      end
      if (state == DONE) last <= gnt;
    end
endmodule

// File: tb/tb_shiftadd_arbiter.sv
// tb_shiftadd_arbiter: transaction-level model of the arbiter driven by a randomized multiplier stub
module tb_shiftadd_arbiter;
  localparam int W  = 4;
  localparam int PW = 2 * W;
  localparam int TO = 31;
  logic clk = 0, rst = 0;
  logic [1:0] req, ack, err;
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic [PW-1:0] res [2];
  logic mul_start, mul_flag;
  logic [W-1:0] mul_a, mul_b;
  logic [PW-1:0] mul_res;
  int vec = 0, miss = 0;
  // model of the arbiter: one operation timeline, cycle numbers measured from the grant
  bit busy, last, gid;
  int gcyc, dcyc, opa, opb;
  int res_m [2];
  bit err_m [2];
  // stimulus state
  int c = 0, t0, s0, rise_c, stale_c, prod;
  bit req_v [2];
  int a_v [2], b_v [2];
  bit rnd_mode = 0, hold = 0, flag_v;
  int force_d = -1, force_stale = -1;
  int ack_cyc [2];
  int ackq [$];

  shiftadd_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .a0(a[0]), .b0(b[0]), .ack0(ack[0]), .res0(res[0]), .err0(err[0]),
    .req1(req[1]), .a1(a[1]), .b1(b[1]), .ack1(ack[1]), .res1(res[1]), .err1(err[1]),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_flag(mul_flag), .mul_res(mul_res)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", c);
    $fatal(1);
  end

  task automatic chk(input string n, input int got, input int exp);
    vec++;
    if (got != exp) begin
      miss++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", n, c, got, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_mul_start", int'(mul_start), 0);
    chk("rst_ack0", int'(ack[0]), 0);
    chk("rst_ack1", int'(ack[1]), 0);
    chk("rst_res0", int'(res[0]), 0);
    chk("rst_res1", int'(res[1]), 0);
    chk("rst_err0", int'(err[0]), 0);
    chk("rst_err1", int'(err[1]), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
  endtask

  task automatic model_reset();
    busy = 0; last = 1; gid = 0; gcyc = -10; dcyc = -1;
    res_m[0] = 0; res_m[1] = 0; err_m[0] = 0; err_m[1] = 0;
    rise_c = 1 << 30; stale_c = -1;
    req_v[0] = 0; req_v[1] = 0;
    req = '0;
  endtask

  task automatic step();
    bit st_e;
    bit ack_e [2];
    int k, d;
    @(negedge clk);
    st_e = busy && c == gcyc + 1;
    chk("mul_start", int'(mul_start), int'(st_e));
    for (int i = 0; i < 2; i++) begin
      ack_e[i] = busy && dcyc >= 0 && c == dcyc + 1 && int'(gid) == i;
      chk(i ? "ack1" : "ack0", int'(ack[i]), int'(ack_e[i]));
      chk(i ? "res1" : "res0", int'(res[i]), res_m[i]);
      chk(i ? "err1" : "err0", int'(err[i]), int'(err_m[i]));
      if (ack[i]) begin
        ackq.push_back(i);
        ack_cyc[i] = c;
      end
    end
    if (busy && c > gcyc) begin
      chk("mul_a", int'(mul_a), opa);
      chk("mul_b", int'(mul_b), opb);
    end
    if (mul_start) begin
      prod = int'(mul_a) * int'(mul_b);
      d = force_d != -1 ? force_d : ($urandom_range(0, 9) == 0 ? -2 : int'($urandom_range(0, 6)));
      rise_c = d == -2 ? c + 100000 : c + d;
      k = force_stale != -1 ? force_stale : int'($urandom_range(0, 2) == 0);
      stale_c = k != 0 ? c + 1 : -1;
    end
    flag_v = c >= rise_c || c == stale_c;
    mul_flag = flag_v;
    mul_res = c >= rise_c ? PW'(prod) : PW'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (ack_e[i] && !hold) req_v[i] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd_mode) begin
        if (!req_v[i]) begin
          a_v[i] = $urandom_range(0, 15);
          b_v[i] = $urandom_range(0, 15);
          if ($urandom_range(0, 2) == 0) req_v[i] = 1;
        end else if (busy && int'(gid) == i && dcyc < 0 && $urandom_range(0, 15) == 0) req_v[i] = 0;
      end
      req[i] = req_v[i];
      a[i] = W'(a_v[i]);
      b[i] = W'(b_v[i]);
    end
    if (!busy) begin
      if (req_v[0] || req_v[1]) begin
        gid = (req_v[0] && req_v[1]) ? !last : req_v[1];
        busy = 1; gcyc = c; dcyc = -1;
        opa = a_v[gid]; opb = b_v[gid];
      end
    end else if (dcyc < 0) begin
      k = c - gcyc - 2;
      if (k >= 1 && flag_v) begin
        dcyc = c; res_m[gid] = opa * opb; err_m[gid] = 0;
      end else if (k == TO - 1) begin
        dcyc = c; res_m[gid] = 0; err_m[gid] = 1;
      end
    end else if (c == dcyc + 1) begin
      busy = 0; last = gid;
    end
    c++;
  endtask

  task automatic op(input int i, input int av, input int bv, input int d, input int st, input int n);
    req_v[i] = 1; a_v[i] = av; b_v[i] = bv;
    force_d = d; force_stale = st;
    ack_cyc[i] = -1000;
    t0 = c;
    repeat (n) step();
  endtask

  initial begin
    a_v[0] = 0; a_v[1] = 0; b_v[0] = 0; b_v[1] = 0;
    mul_flag = 0; mul_res = '0;
    a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    model_reset();
    rst = 1;
    @(negedge clk);
    reset_checks();
    rst = 0;
    // simultaneous requests straight after reset: requester 0 first
    req_v[1] = 1; a_v[1] = 15; b_v[1] = 15;
    ackq.delete();
    op(0, 3, 5, 2, 0, 15);
    chk("t2_first", ackq.size() > 0 ? ackq[0] : -1, 0);
    chk("t2_second", ackq.size() > 1 ? ackq[1] : -1, 1);
    chk("t2_res0", int'(res[0]), 15);
    chk("t2_res1", int'(res[1]), 225);
    chk("t2_model_res1", res_m[1], 225);
    chk("t2_last", int'(last), 1);
    // single request, flag five cycles after start
    ackq.delete();
    s0 = vec;
    op(0, 4, 6, 5, 0, 12);
    chk("t1_latency", ack_cyc[0] - t0, 7);
    chk("t1_res0", int'(res[0]), 24);
    chk("t1_err0", int'(err[0]), 0);
    chk("t1_acks", ackq.size(), 1);
    chk("t1_ack_id", ackq.size() > 0 ? ackq[0] : -1, 0);
    // both held for four operations: strict alternation, requester 1 first since 0 went last
    ackq.delete();
    hold = 1; force_d = 1; force_stale = 0;
    req_v[0] = 1; req_v[1] = 1;
    a_v[0] = 2; b_v[0] = 3; a_v[1] = 5; b_v[1] = 6;
    repeat (20) step();
    req_v[0] = 0; req_v[1] = 0; hold = 0;
    repeat (8) step();
    chk("t3_count", ackq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", ackq.size() > i ? ackq[i] : -1, (i + 1) % 2);
    chk("t3_res0", int'(res[0]), 6);
    chk("t3_res1", int'(res[1]), 30);
    // multiplier never answers: watchdog abort, then a normal operation
    op(0, 3, 3, -2, 0, 40);
    chk("t4_latency", ack_cyc[0] - t0, 33);
    chk("t4_err0", int'(err[0]), 1);
    chk("t4_res0", int'(res[0]), 0);
    op(0, 5, 5, 2, 0, 10);
    chk("t4_next_res0", int'(res[0]), 25);
    chk("t4_next_err0", int'(err[0]), 0);
    // flag high (with junk product) in the first WAIT cycle must be ignored
    op(1, 7, 9, 4, 1, 12);
    chk("t5_latency", ack_cyc[1] - t0, 6);
    chk("t5_res1", int'(res[1]), 63);
    // randomized traffic
    rnd_mode = 1; force_d = -1; force_stale = -1;
    repeat (600) step();
    rnd_mode = 0;
    repeat (80) step();
    // asynchronous reset during WAIT
    op(1, 9, 9, -2, 0, 4);
    #2 rst = 1;
    #1 reset_checks();
    model_reset();
    @(negedge clk);
    rst = 0;
    ackq.delete();
    repeat (5) step();
    chk("t6_no_ack", ackq.size(), 0);
    op(1, 2, 7, 2, 0, 10);
    chk("t6_res1", int'(res[1]), 14);
    ackq.delete();
    req_v[1] = 1; a_v[1] = 3; b_v[1] = 3;
    op(0, 1, 1, 2, 0, 15);
    chk("t6_tie_first", ackq.size() > 0 ? ackq[0] : -1, 0);
    chk("t6_tie_res1", int'(res[1]), 9);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
